alu_issuer: RTL and testbench

Sequential front-end that drives the team's combinational 64-bit ALU (`alu`: operands A/B, 4-bit select, result plus zero flag). It accepts one operation per request over a valid/ready handshake, registers operands and select onto the ALU inputs, and holds them stable for a settle window. It then captures the ALU result and zero flag and returns them with the request tag over a second valid/ready handshake. Divide-by-zero is trapped locally and never reaches the ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_issuer_if.sv | 36 +++
 rtl/alu.sv | 47 ++++
 rtl/alu_issuer.sv | 123 ++++++++++++
 tb/tb_alu_issuer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequential issuer:
// op-code map, issuer state encoding and the slow-op helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic is_slow(logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Request/response handshake bundle between a requester
// (master) and the ALU issuer (slave).
interface alu_issuer_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_z;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_z, rsp_err, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_z, rsp_err, rsp_tag,
        input  rsp_ready
    );

endinterface

// File: rtl/alu.sv
// Combinational 64-bit ALU driven by alu_issuer.
// Unknown/zero select falls through to ADD.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             z
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] WBITS = (SW + 1)'(WIDTH);

    logic [SW-1:0] sh;
    logic [SW:0]   rsh;

    // Operation select; the default arm doubles as ADD.
    always_comb begin
        sh  = b[SW-1:0];
        rsh = WBITS - {1'b0, sh};
        out = a + b;
        case (sel)
            OP_SUB:  out = a - b;
            OP_MUL:  out = a * b;
            OP_DIV:  out = (b == '0) ? '1 : a / b;
            OP_SHL:  out = a << sh;
            OP_SHR:  out = a >> sh;
            OP_ROL:  out = (a << sh) | (a >> rsh);
            OP_ROR:  out = (a >> sh) | (a << rsh);
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_NOR:  out = ~(a | b);
            OP_NAND: out = ~(a & b);
            OP_XNOR: out = ~(a ^ b);
            OP_GT:   out = {{(WIDTH-1){1'b0}}, a > b};
            OP_EQ:   out = {{(WIDTH-1){1'b0}}, a == b};
            default: out = a + b;
        endcase
        z = (out == '0);
    end

endmodule

// File: rtl/alu_issuer.sv
// Sequential front-end for the combinational ALU: registers
// operands, waits a settle window, returns result with tag.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issuer_if.slave      bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             z_q, z_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       sel_q, sel_d;

    logic trap;

    // Next-state and datapath load decisions for the issuer FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        data_d  = data_q;
        z_d     = z_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        trap    = (bus.req_op == OP_DIV) && (bus.req_b == '0);
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    tag_d   = bus.req_tag;
                    state_d = S_EXEC;
                    if (trap) begin
                        // Trap result is preloaded; it rides a one-cycle
                        // EXEC so its latency matches a fast op.
                        data_d = '1;
                        z_d    = 1'b0;
                        err_d  = 1'b1;
                        cnt_d  = 4'd1;
                    end else begin
                        a_d   = bus.req_a;
                        b_d   = bus.req_b;
                        sel_d = bus.req_op;
                        err_d = 1'b0;
                        cnt_d = is_slow(bus.req_op) ? SETTLE : 4'd1;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd1) begin
                    if (!err_q) begin
                        data_d = alu_out;
                        z_d    = alu_z;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, ALU input and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            z_q     <= z_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_z     = z_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_tag   = tag_q;

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer driving the alu model
// alongside it; random ops checked against a reference model.
module tb_alu_issuer;
    import alu_pkg::*;

    localparam int SETTLE = 3;

    typedef struct {
        logic [63:0] d;
        logic        z;
        logic        e;
        logic [3:0]  tag;
        int          acc;
        int          lat;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_z;

    alu_issuer_if #(.WIDTH(64), .TAG_W(4)) bus ();

    alu_issuer #(
        .WIDTH(64), .TAG_W(4), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_z(alu_z)
    );

    alu #(.WIDTH(64)) u_alu (
        .a(alu_a), .b(alu_b), .sel(alu_sel),
        .out(alu_out), .z(alu_z)
    );

    item_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_hs = -100;
    int          last_acc = 0;
    logic [63:0] mdl_a = '0, mdl_b = '0;
    logic [3:0]  mdl_op = '0;
    logic        rand_rdy = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] ref_alu(logic [3:0] op,
                                            logic [63:0] a,
                                            logic [63:0] b);
        int           s;
        logic [127:0] aa;
        logic [127:0] t;
        s  = int'(b[5:0]);
        aa = {a, a};
        case (op)
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return a / b;
            OP_SHL:  return a << s;
            OP_SHR:  return a >> s;
            OP_ROL:  begin t = aa << s; return t[127:64]; end
            OP_ROR:  begin t = aa >> s; return t[63:0]; end
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_NAND: return ~(a & b);
            OP_XNOR: return ~(a ^ b);
            OP_GT:   return (a > b) ? 64'd1 : 64'd0;
            OP_EQ:   return (a == b) ? 64'd1 : 64'd0;
            default: return a + b;
        endcase
    endfunction

    // Monitor: compares every presented response against the queue head.
    initial begin
        item_t it;
        bit    seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
                continue;
            end
            if (!bus.req_ready) begin
                chk("alu_a_hold", alu_a, mdl_a);
                chk("alu_b_hold", alu_b, mdl_b);
                chk("alu_sel_hold", 64'(alu_sel), 64'(mdl_op));
            end
            if (bus.rsp_valid) begin
                chk("ready_in_resp", 64'(bus.req_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    it = exp_q[0];
                    if (!seen) begin
                        chk("latency", 64'(cyc - it.acc), 64'(it.lat));
                        seen = 1;
                    end
                    chk("rsp_data", bus.rsp_data, it.d);
                    chk("rsp_z", 64'(bus.rsp_z), 64'(it.z));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(it.e));
                    chk("rsp_tag", 64'(bus.rsp_tag), 64'(it.tag));
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        seen = 0;
                        last_hs = cyc + 1;
                    end
                end
            end
        end
    end

    // Random consumer backpressure during the random phase.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] tag);
        item_t it;
        int    n;
        n = 0;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 200);
        if (!bus.req_ready) begin
            chk("accept_timeout", 64'(bus.req_ready), 64'd1);
        end else begin
            it.tag = tag;
            it.acc = cyc + 1;
            if (op == OP_DIV && b == 64'd0) begin
                it.d = '1;
                it.z = 1'b0;
                it.e = 1'b1;
                it.lat = 1;
            end else begin
                it.d = ref_alu(op, a, b);
                it.z = (it.d == 64'd0);
                it.e = 1'b0;
                it.lat = (op == OP_MUL || op == OP_DIV) ? SETTLE : 1;
                mdl_a  = a;
                mdl_b  = b;
                mdl_op = op;
            end
            last_acc = it.acc;
            exp_q.push_back(it);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(string tagname);
        chk({tagname, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tagname, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tagname, "_rsp_data"}, bus.rsp_data, 64'd0);
        chk({tagname, "_rsp_z"}, 64'(bus.rsp_z), 64'd0);
        chk({tagname, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        chk({tagname, "_rsp_tag"}, 64'(bus.rsp_tag), 64'd0);
        chk({tagname, "_alu_a"}, alu_a, 64'd0);
        chk({tagname, "_alu_b"}, alu_b, 64'd0);
        chk({tagname, "_alu_sel"}, 64'(alu_sel), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed ops.
        bus.rsp_ready = 1'b1;
        issue(OP_ADD, 64'd5, 64'd7, 4'd3);
        drain();
        issue(OP_SUB, 64'd9, 64'd9, 4'd1);
        drain();
        issue(OP_EQ, 64'd4, 64'd4, 4'd2);
        drain();
        issue(OP_MUL, 64'd6, 64'd7, 4'd4);
        @(negedge clk);
        chk("mul_exec_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("mul_exec_ready2", 64'(bus.req_ready), 64'd0);
        drain();
        issue(OP_DIV, 64'd100, 64'd0, 4'd9);
        drain();

        // Backpressure with a pending second request.
        bus.rsp_ready = 1'b0;
        issue(OP_ADD, 64'd1, 64'd2, 4'd5);
        bus.req_op    = OP_ADD;
        bus.req_a     = 64'd10;
        bus.req_b     = 64'd20;
        bus.req_tag   = 4'd6;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        issue(OP_ADD, 64'd10, 64'd20, 4'd6);
        chk("bp_next_accept", 64'(last_acc - last_hs), 64'd1);
        drain();

        // Randomized traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 3));
            if (op == OP_DIV && $urandom_range(0, 3) == 0) b = 64'd0;
            if (op == OP_SUB && $urandom_range(0, 3) == 0) b = a;
            issue(op, a, b, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.rsp_ready = 1'b1;
        drain();

        // Reset in the middle of a MUL settle window.
        bus.rsp_ready = 1'b0;
        issue(OP_MUL, 64'd11, 64'd13, 4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        mdl_a  = '0;
        mdl_b  = '0;
        mdl_op = '0;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(OP_ADD, 64'd40, 64'd2, 4'd8);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
